if_fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID register for the 32-bit MIPS pipeline. Owns the PC, runs a
//  req/ack handshake with instruction memory, and holds the fetched word with its decoded fields
//  for the decode stage; id_imm feeds sign_extend, the rest feed the register file and control.

---
 rtl/if_fetch_stage_if.sv | 15 +
 rtl/if_fetch_stage.sv | 162 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch handshake bundle.
//   req   : fetch request, held until ack
//   addr  : word-aligned fetch address, stable while req is high
//   ack   : one-cycle pulse, rdata valid in the same cycle
//   rdata : instruction word
// master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage plus IF/ID register for the 32-bit MIPS pipeline.
// Owns the PC, runs a req/ack handshake with instruction memory, holds the
// fetched word and its decoded fields for decode. A one-entry skid buffer
// absorbs a word returned while decode is stalled; a redirect arriving while
// a request is outstanding parks the target and drops the stale word (KILL).
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   imem               fetch handshake (master side)
//   stall              decode cannot accept a new instruction this cycle
//   redirect_valid/pc  taken branch/jump target (bits [1:0] forced to 0)
//   id_valid, id_instr, id_pc_plus4   IF/ID register
//   id_opcode..id_jaddr               fields sliced combinationally from id_instr
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   if_fetch_stage_if.master      imem,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   output logic                  id_valid,
   output logic [31:0]           id_instr,
   output logic [31:0]           id_pc_plus4,
   output logic [5:0]            id_opcode,
   output logic [4:0]            id_rs,
   output logic [4:0]            id_rt,
   output logic [4:0]            id_rd,
   output logic [4:0]            id_shamt,
   output logic [5:0]            id_funct,
   output logic [15:0]           id_imm,
   output logic [25:0]           id_jaddr
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, KILL} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic        valid_q, valid_n;
   logic [31:0] instr_q, instr_n;
   logic [31:0] pc4_q, pc4_n;
   logic [31:0] buf_instr, buf_instr_n;
   logic [31:0] buf_pc4, buf_pc4_n;
   logic [31:0] kill_tgt, kill_tgt_n;

   logic [31:0] redir_tgt;
   logic [31:0] pc_inc;

   assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;
   assign pc_inc    = pc + 32'd4;

   assign imem.req  = (state == FETCH) || (state == KILL);
   assign imem.addr = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         valid_q   <= 1'b0;
         instr_q   <= '0;
         pc4_q     <= '0;
         buf_instr <= '0;
         buf_pc4   <= '0;
         kill_tgt  <= '0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         valid_q   <= valid_n;
         instr_q   <= instr_n;
         pc4_q     <= pc4_n;
         buf_instr <= buf_instr_n;
         buf_pc4   <= buf_pc4_n;
         kill_tgt  <= kill_tgt_n;
      end
   end

   always_comb begin
      state_n     = state;
      pc_n        = pc;
      valid_n     = valid_q;
      instr_n     = instr_q;
      pc4_n       = pc4_q;
      buf_instr_n = buf_instr;
      buf_pc4_n   = buf_pc4;
      kill_tgt_n  = kill_tgt;

      // Redirect outranks stall and ack everywhere and always flushes ID.
      if (redirect_valid) begin
         valid_n = 1'b0;
         instr_n = '0;
      end

      unique case (state)
         IDLE: begin
            if (redirect_valid) pc_n = redir_tgt;
            state_n = FETCH;
         end
         FETCH: begin
            if (redirect_valid) begin
               if (imem.ack) begin
                  pc_n = redir_tgt;
               end else begin
                  // Request still outstanding: park target, drop its word later.
                  kill_tgt_n = redir_tgt;
                  state_n    = KILL;
               end
            end else if (imem.ack) begin
               pc_n = pc_inc;
               if (!stall) begin
                  instr_n = imem.rdata;
                  pc4_n   = pc_inc;
                  valid_n = 1'b1;
               end else begin
                  buf_instr_n = imem.rdata;
                  buf_pc4_n   = pc_inc;
                  state_n     = HOLD;
               end
            end else if (!stall) begin
               valid_n = 1'b0;
               instr_n = '0;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_n    = redir_tgt;
               state_n = FETCH;
            end else if (!stall) begin
               instr_n = buf_instr;
               pc4_n   = buf_pc4;
               valid_n = 1'b1;
               state_n = FETCH;
            end
         end
         KILL: begin
            if (redirect_valid) begin
               kill_tgt_n = redir_tgt;
               if (imem.ack) begin
                  pc_n    = redir_tgt;
                  state_n = FETCH;
               end
            end else if (imem.ack) begin
               pc_n    = kill_tgt;
               state_n = FETCH;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign id_valid    = valid_q;
   assign id_instr    = instr_q;
   assign id_pc_plus4 = pc4_q;
   assign id_opcode   = instr_q[31:26];
   assign id_rs       = instr_q[25:21];
   assign id_rt       = instr_q[20:16];
   assign id_rd       = instr_q[15:11];
   assign id_shamt    = instr_q[10:6];
   assign id_funct    = instr_q[5:0];
   assign id_imm      = instr_q[15:0];
   assign id_jaddr    = instr_q[25:0];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with hand-computed expectations.
module tb_if_fetch_stage;
   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid;
   logic [31:0] id_instr, id_pc_plus4;
   logic [5:0]  id_opcode, id_funct;
   logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
   logic [15:0] id_imm;
   logic [25:0] id_jaddr;

   int n_checks = 0;
   int n_errors = 0;

   if_fetch_stage_if imem ();

   if_fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .imem(imem.master), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
      .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_shamt(id_shamt), .id_funct(id_funct), .id_imm(id_imm), .id_jaddr(id_jaddr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ack_word(input logic [31:0] w);
      imem.ack   = 1'b1;
      imem.rdata = w;
   endtask

   initial begin
      imem.ack   = 1'b0;
      imem.rdata = '0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_req",   {31'd0, imem.req}, 32'd0);
      check("rst_valid", {31'd0, id_valid}, 32'd0);
      check("rst_instr", id_instr, 32'd0);
      check("rst_pc4",   id_pc_plus4, 32'd0);
      step(); step();
      #2 rst_n = 1'b1;

      // 1: first fetch at RESET_PC, addi-style word
      step();
      check("t1_req",  {31'd0, imem.req}, 32'd1);
      check("t1_addr", imem.addr, 32'h0040_0000);
      ack_word(32'h2008_FFFF);
      step();
      imem.ack = 1'b0;
      check("t1_valid", {31'd0, id_valid}, 32'd1);
      check("t1_imm",   {16'd0, id_imm}, 32'h0000_FFFF);
      check("t1_rt",    {27'd0, id_rt}, 32'd8);
      check("t1_op",    {26'd0, id_opcode}, 32'h08);
      check("t1_pc4",   id_pc_plus4, 32'h0040_0004);
      check("t1_next",  imem.addr, 32'h0040_0004);

      // 2: word returns under stall, sits in skid buffer for 3 cycles
      ack_word(32'h8C09_0004);
      stall = 1'b1;
      step();
      imem.ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t2_hold_req",   {31'd0, imem.req}, 32'd0);
         check("t2_hold_instr", id_instr, 32'h2008_FFFF);
         if (i < 2) step();
      end
      stall = 1'b0;
      step();
      check("t2_instr", id_instr, 32'h8C09_0004);
      check("t2_valid", {31'd0, id_valid}, 32'd1);
      check("t2_pc4",   id_pc_plus4, 32'h0040_0008);
      check("t2_req",   {31'd0, imem.req}, 32'd1);
      check("t2_addr",  imem.addr, 32'h0040_0008);

      // 5: redirect + stall + ack together in FETCH
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0010;
      stall          = 1'b1;
      ack_word(32'hCAFE_F00D);
      step();
      redirect_valid = 1'b0;
      stall          = 1'b0;
      imem.ack       = 1'b0;
      check("t5_valid", {31'd0, id_valid}, 32'd0);
      check("t5_instr", id_instr, 32'd0);
      check("t5_addr",  imem.addr, 32'h0000_0010);
      check("t5_req",   {31'd0, imem.req}, 32'd1);

      // 3: redirect while request at 0x10 outstanding, target 0x43 -> 0x40
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0043;
      step();
      redirect_valid = 1'b0;
      check("t3_addr_a", imem.addr, 32'h0000_0010);
      check("t3_req_a",  {31'd0, imem.req}, 32'd1);
      check("t3_valid",  {31'd0, id_valid}, 32'd0);
      step();
      check("t3_addr_b", imem.addr, 32'h0000_0010);
      ack_word(32'hDEAD_BEEF);
      step();
      imem.ack = 1'b0;
      check("t3_killed", id_instr, 32'd0);
      check("t3_kvalid", {31'd0, id_valid}, 32'd0);
      check("t3_addr_c", imem.addr, 32'h0000_0040);
      ack_word(32'h0000_0020);
      step();
      imem.ack = 1'b0;
      check("t3_instr", id_instr, 32'h0000_0020);
      check("t3_pc4",   id_pc_plus4, 32'h0000_0044);

      // 4: wrap at top of address space, field slicing
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      ack_word(32'h0BAD_0BAD);
      step();
      redirect_valid = 1'b0;
      imem.ack       = 1'b0;
      check("t4_addr", imem.addr, 32'hFFFF_FFFC);
      ack_word(32'h1234_5678);
      step();
      imem.ack = 1'b0;
      check("t4_pc4",   id_pc_plus4, 32'd0);
      check("t4_next",  imem.addr, 32'd0);
      check("t4_instr", id_instr, 32'h1234_5678);
      check("t4_op",    {26'd0, id_opcode}, 32'h04);
      check("t4_rs",    {27'd0, id_rs}, 32'h11);
      check("t4_rt",    {27'd0, id_rt}, 32'h14);
      check("t4_rd",    {27'd0, id_rd}, 32'h0A);
      check("t4_shamt", {27'd0, id_shamt}, 32'h19);
      check("t4_funct", {26'd0, id_funct}, 32'h38);
      check("t4_jaddr", {6'd0, id_jaddr}, 32'h0234_5678);

      // stall alone keeps ID; releasing with nothing fetched issues a bubble
      stall = 1'b1;
      step();
      check("stall_keep", id_instr, 32'h1234_5678);
      stall = 1'b0;
      step();
      check("bubble_valid", {31'd0, id_valid}, 32'd0);
      check("bubble_instr", id_instr, 32'd0);

      // 6: async reset while in HOLD
      ack_word(32'hAAAA_5555);
      stall = 1'b1;
      step();
      imem.ack = 1'b0;
      check("t6_hold_req", {31'd0, imem.req}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("t6_req",   {31'd0, imem.req}, 32'd0);
      check("t6_valid", {31'd0, id_valid}, 32'd0);
      check("t6_instr", id_instr, 32'd0);
      stall = 1'b0;
      #2 rst_n = 1'b1;
      ack_word(32'h0000_BBBB);   // late ack, lands in IDLE
      step();
      imem.ack = 1'b0;
      check("t6_late_valid", {31'd0, id_valid}, 32'd0);
      check("t6_req_post",   {31'd0, imem.req}, 32'd1);
      check("t6_addr_post",  imem.addr, RST_PC);
      ack_word(32'h1111_2222);
      step();
      imem.ack = 1'b0;
      check("t6_instr_post", id_instr, 32'h1111_2222);
      check("t6_pc4_post",   id_pc_plus4, 32'h0040_0004);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
